// File: rtl/regfile_fwd_pkg.sv
// Shared tag layout and helpers for the forwarding register file.
package regfile_fwd_pkg;

    localparam int unsigned TAG_W   = 6;
    localparam int unsigned TAG_VLD = 5;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned NREG    = 32;

    // Ceiling log2; clog2(1) = 0
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned v = 1; v < value; v = v << 1) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_fwd_sb.sv
// Load-use scoreboard: per-register countdown of outstanding load latency.
module regfile_fwd_sb
    import regfile_fwd_pkg::*;
#(
    parameter int unsigned NREAD    = 2,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rd_valid,
    input  logic [NREAD*TAG_W-1:0] rd_addr,
    input  logic                   ld_issue,
    input  logic [TAG_W-1:0]       ld_wbr,
    input  logic                   flush,
    output logic                   hazard
);

    // A one-cycle load never leaves a nonzero count; keep a 1-bit counter anyway
    localparam int unsigned CNT_W = (clog2(LOAD_LAT) > 0) ? clog2(LOAD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_LAT - 1);

    logic [CNT_W-1:0] cnt [NREG];
    logic             hazard_c;

    // Counters: flush wins over a same-cycle issue; reissue reloads
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < int'(NREG); r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < int'(NREG); r++) begin
                if (flush) begin
                    cnt[r] <= '0;
                end else if (ld_issue && ld_wbr[TAG_VLD] && (ld_wbr[IDX_W-1:0] == IDX_W'(r))) begin
                    cnt[r] <= CNT_LOAD;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    // Hazard: a real-register operand hits the issuing load or a pending one
    always_comb begin
        hazard_c = 1'b0;
        for (int p = 0; p < int'(NREAD); p++) begin
            if (rd_addr[p*TAG_W + TAG_VLD]) begin
                if (ld_issue && (rd_addr[p*TAG_W +: TAG_W] == ld_wbr)) begin
                    hazard_c = 1'b1;
                end
                if (cnt[rd_addr[p*TAG_W +: IDX_W]] != '0) begin
                    hazard_c = 1'b1;
                end
            end
        end
        hazard_c = hazard_c & rd_valid;
    end

    // Hazard is reported in the cycle after the request
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hazard <= 1'b0;
        end else begin
            hazard <= hazard_c;
        end
    end

endmodule

// File: rtl/regfile_fwd.sv
// Register file with per-port array copies, producer forwarding and commit history.
module regfile_fwd
    import regfile_fwd_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned NSTAGE   = 2,
    parameter int unsigned WHIST    = 1,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rd_valid,
    input  logic [NREAD*TAG_W-1:0]  rd_addr,
    output logic [NREAD*XLEN-1:0]   rd_val,
    output logic                    hazard,
    input  logic [NSTAGE-1:0]       fwd_valid,
    input  logic [NSTAGE*TAG_W-1:0] fwd_wbr,
    input  logic [NSTAGE*XLEN-1:0]  fwd_res,
    input  logic                    wr_valid,
    input  logic [TAG_W-1:0]        wr_wbr,
    input  logic [XLEN-1:0]         wr_res,
    input  logic                    ld_issue,
    input  logic [TAG_W-1:0]        ld_wbr,
    input  logic                    flush
);

    localparam int unsigned HDEPTH = (WHIST > 0) ? WHIST : 1;

    logic [XLEN-1:0]  mem      [NREAD][NREG];
    logic [XLEN-1:0]  arr_q    [NREAD];
    logic [TAG_W-1:0] tag_q    [NREAD];
    logic             hist_v   [HDEPTH];
    logic [TAG_W-1:0] hist_wbr [HDEPTH];
    logic [XLEN-1:0]  hist_res [HDEPTH];
    logic             wr_en_c;
    logic             sel_hit;
    logic [XLEN-1:0]  sel_val;

    // Entry 0 is never written so r0 always reads as zero
    assign wr_en_c = wr_valid && wr_wbr[TAG_VLD] && (wr_wbr[IDX_W-1:0] != '0);

    // Array copies: shared write, per-port synchronous read (old data on collision)
    always_ff @(posedge clock) begin
        for (int p = 0; p < int'(NREAD); p++) begin
            if (wr_en_c) begin
                mem[p][wr_wbr[IDX_W-1:0]] <= wr_res;
            end
            arr_q[p] <= (rd_addr[p*TAG_W +: IDX_W] == '0) ? '0 : mem[p][rd_addr[p*TAG_W +: IDX_W]];
        end
    end

    // Registered read tags for next-cycle matching
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < int'(NREAD); p++) begin
                tag_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < int'(NREAD); p++) begin
                tag_q[p] <= rd_addr[p*TAG_W +: TAG_W];
            end
        end
    end

    // History valids shift every cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int h = 0; h < int'(HDEPTH); h++) begin
                hist_v[h] <= 1'b0;
            end
        end else begin
            hist_v[0] <= wr_valid;
            for (int h = 1; h < int'(HDEPTH); h++) begin
                hist_v[h] <= hist_v[h-1];
            end
        end
    end

    // History payload follows its valid; no reset needed
    always_ff @(posedge clock) begin
        hist_wbr[0] <= wr_wbr;
        hist_res[0] <= wr_res;
        for (int h = 1; h < int'(HDEPTH); h++) begin
            hist_wbr[h] <= hist_wbr[h-1];
            hist_res[h] <= hist_res[h-1];
        end
    end

    // Operand select: fwd stages youngest first, then commit, then history, then array
    always_comb begin
        rd_val  = '0;
        sel_hit = 1'b0;
        sel_val = '0;
        for (int p = 0; p < int'(NREAD); p++) begin
            sel_hit = 1'b0;
            sel_val = arr_q[p];
            if (tag_q[p][TAG_VLD]) begin
                for (int s = 0; s < int'(NSTAGE); s++) begin
                    if (!sel_hit && fwd_valid[s] && (fwd_wbr[s*TAG_W +: TAG_W] == tag_q[p])) begin
                        sel_hit = 1'b1;
                        sel_val = fwd_res[s*XLEN +: XLEN];
                    end
                end
                if (!sel_hit && wr_valid && (wr_wbr == tag_q[p])) begin
                    sel_hit = 1'b1;
                    sel_val = wr_res;
                end
                for (int h = 0; h < int'(WHIST); h++) begin
                    if (!sel_hit && hist_v[h] && (hist_wbr[h] == tag_q[p])) begin
                        sel_hit = 1'b1;
                        sel_val = hist_res[h];
                    end
                end
            end
            rd_val[p*XLEN +: XLEN] = sel_val;
        end
    end

    regfile_fwd_sb #(
        .NREAD    (NREAD),
        .LOAD_LAT (LOAD_LAT)
    ) u_sb (
        .clock    (clock),
        .reset    (reset),
        .rd_valid (rd_valid),
        .rd_addr  (rd_addr),
        .ld_issue (ld_issue),
        .ld_wbr   (ld_wbr),
        .flush    (flush),
        .hazard   (hazard)
    );

endmodule
